// File: rtl/store_trace_fifo.sv
// store_trace_fifo: show-ahead capture FIFO for data-memory stores with sequence tags, sticky overflow and watched-store match.
module store_trace_fifo #(
  parameter int            N          = 16,
  parameter int            DEPTH      = 8,
  parameter logic [N-1:0]  WATCH_ADDR = N'(84),
  parameter logic [N-1:0]  WATCH_DATA = N'('h0096)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [N-1:0]             dataadr,
  input  logic [N-1:0]             writedata,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [N-1:0]             rd_addr,
  output logic [N-1:0]             rd_data,
  output logic [7:0]               rd_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     match,
  output logic [7:0]               match_seq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * N + 8;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    seq_q, seq_d, mseq_q, mseq_d;
  logic          ovf_q, ovf_d, match_q, match_d;
  logic          full, pop, push, drop, hit;
  logic [EW-1:0] head;
  // clear suppresses every other update in its cycle, so gate all events with it here
  always_comb begin
    full     = count_q == CW'(DEPTH);
    rd_valid = count_q != '0;
    pop      = rd_valid && rd_ready && !clear;
    push     = memwrite && !clear && (!full || pop);
    drop     = memwrite && !clear && full && !pop;
    hit      = memwrite && !clear && dataadr == WATCH_ADDR && writedata == WATCH_DATA;
    count_d  = clear ? '0 : (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    wptr_d   = clear ? '0 : push ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = clear ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
    seq_d    = clear ? '0 : memwrite ? seq_q + 8'd1 : seq_q;
    ovf_d    = clear ? 1'b0 : ovf_q | drop;
    match_d  = clear ? 1'b0 : match_q | hit;
    mseq_d   = clear ? '0 : (hit && !match_q) ? seq_q : mseq_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
      mseq_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
      mseq_q  <= mseq_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {dataadr, writedata, seq_q};
  end
  // head fields read as zero when empty, so stale storage never shows after reset or clear
  always_comb begin
    head      = rd_valid ? mem_q[rptr_q] : '0;
    rd_addr   = head[EW-1:N+8];
    rd_data   = head[N+7:8];
    rd_seq    = head[7:0];
    count     = count_q;
    overflow  = ovf_q;
    match     = match_q;
    match_seq = mseq_q;
  end
endmodule

// File: tb/tb_store_trace_fifo.sv
// tb_store_trace_fifo: directed scenario tasks with inline expected-value checks for store_trace_fifo.
module tb_store_trace_fifo;
  logic        clk = 1'b0, reset = 1'b0, memwrite = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic [15:0] dataadr = '0, writedata = '0;
  logic        rd_valid, overflow, match;
  logic [15:0] rd_addr, rd_data;
  logic [7:0]  rd_seq, match_seq;
  logic [3:0]  count;
  int          n_checks = 0, n_fail = 0;

  store_trace_fifo dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_seq(rd_seq), .count(count), .overflow(overflow), .match(match), .match_seq(match_seq)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; memwrite = 1'b1; dataadr = 16'd84; writedata = 16'h0096;
    repeat (3) step();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b want 0", match); end
    memwrite = 1'b0; reset = 1'b1;
    step();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_release_count got %0d want 0", count); end
  endtask

  task automatic test_single;
    memwrite = 1'b1; dataadr = 16'h0010; writedata = 16'h1234;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b want 0", rd_valid); end
    step();
    memwrite = 1'b0;
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rd_valid); end
    n_checks++; if (rd_addr !== 16'h0010) begin n_fail++; $display("FAIL single_addr got %h want 0010", rd_addr); end
    n_checks++; if (rd_data !== 16'h1234) begin n_fail++; $display("FAIL single_data got %h want 1234", rd_data); end
    n_checks++; if (rd_seq !== 8'd0) begin n_fail++; $display("FAIL single_seq got %0d want 0", rd_seq); end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b want 0", rd_valid); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_pop_count got %0d want 0", count); end
  endtask

  task automatic test_overflow;
    do_clear();
    for (int i = 0; i < 10; i++) store(16'(i), 16'(16'h0100 + i));
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_seq !== 8'(i) || rd_data !== 16'(16'h0100 + i)) begin n_fail++; $display("FAIL ovf_drain_%0d got seq %0d data %h want seq %0d data %h", i, rd_seq, rd_data, i, 16'h0100 + i); end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid got %b want 0", rd_valid); end
    store(16'h00AA, 16'h5555);
    n_checks++; if (rd_seq !== 8'd10) begin n_fail++; $display("FAIL ovf_next_seq got %0d want 10", rd_seq); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop;
    do_clear();
    for (int i = 0; i < 8; i++) store(16'(16'h0200 + i), 16'(16'hA000 + i));
    memwrite = 1'b1; rd_ready = 1'b1; dataadr = 16'h0077; writedata = 16'hBEEF;
    step();
    memwrite = 1'b0; rd_ready = 1'b0;
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_pp_count got %0d want 8", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_overflow got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_seq !== 8'(i + 1)) begin n_fail++; $display("FAIL full_pp_drain_%0d got seq %0d want %0d", i, rd_seq, i + 1); end
      if (i == 7) begin
        n_checks++; if (rd_addr !== 16'h0077 || rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL full_pp_tail got %h/%h want 0077/beef", rd_addr, rd_data); end
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_pp_empty got %0d want 0", count); end
  endtask

  task automatic test_match;
    do_clear();
    for (int j = 0; j < 5; j++) begin
      if (j == 2 || j == 4) store(16'd84, 16'h0096);
      else store(16'(16'h0040 + j), 16'(j));
      n_checks++; if (match !== (j >= 2)) begin n_fail++; $display("FAIL match_after_%0d got %b want %b", j, match, j >= 2); end
    end
    n_checks++; if (match_seq !== 8'd2) begin n_fail++; $display("FAIL match_seq got %0d want 2", match_seq); end
    store(16'd84, 16'h0097);
    n_checks++; if (match_seq !== 8'd2) begin n_fail++; $display("FAIL match_seq_near_miss got %0d want 2", match_seq); end
    do_clear();
    for (int i = 0; i < 8; i++) store(16'(i), 16'h0096);
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL match_wrong_addr got %b want 0", match); end
    store(16'd84, 16'h0096);
    n_checks++; if (overflow !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL match_drop_state got ovf %b count %0d want 1 8", overflow, count); end
    n_checks++; if (match !== 1'b1 || match_seq !== 8'd8) begin n_fail++; $display("FAIL match_dropped got %b seq %0d want 1 seq 8", match, match_seq); end
  endtask

  task automatic test_wrap_and_clear;
    do_clear();
    rd_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      store(16'(k), 16'(k ^ 16'h5A5A));
      n_checks++; if (rd_valid !== 1'b1 || rd_seq !== 8'(k) || count !== 4'd1) begin n_fail++; $display("FAIL wrap_%0d got v %b seq %0d count %0d want 1 %0d 1", k, rd_valid, rd_seq, count, k % 256); end
    end
    clear = 1'b1; memwrite = 1'b1; dataadr = 16'd84; writedata = 16'h0096;
    step();
    clear = 1'b0; memwrite = 1'b0; rd_ready = 1'b0;
    n_checks++; if (count !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_count got %0d want 0", count); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL clear_match got %b want 0", match); end
    store(16'h0033, 16'h4444);
    n_checks++; if (rd_seq !== 8'd0 || rd_data !== 16'h4444) begin n_fail++; $display("FAIL clear_seq_restart got seq %0d data %h want 0 4444", rd_seq, rd_data); end
  endtask

  task automatic test_async_reset;
    do_clear();
    for (int i = 0; i < 3; i++) store(16'(i), 16'(i));
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL areset_pre_count got %0d want 3", count); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_async got count %0d valid %b want 0 0", count, rd_valid); end
    step();
    reset = 1'b1;
    store(16'h0001, 16'h0002);
    n_checks++; if (rd_seq !== 8'd0 || count !== 4'd1) begin n_fail++; $display("FAIL areset_restart got seq %0d count %0d want 0 1", rd_seq, count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_match();
    test_wrap_and_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
